lwc_decrypt: RTL and testbench

LWC_DECRYPT -- requirements
Module: lwc_decrypt

---
 rtl/lwc_decrypt.sv | 134 +++++++++++++
 tb/tb_lwc_decrypt.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/lwc_decrypt.sv
// lwc_decrypt -- iterative decryptor for the team's lightweight 128-bit cipher.
// One inverse round per clock; IDLE accepts a block, ROUND runs NUM_ROUNDS
// cycles, DONE holds the result until the consumer takes it.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   ciphertext/key offered
//   in_ready   block can be accepted (IDLE only)
//   ciphertext 128-bit block to decrypt
//   key        128-bit key, sampled together with ciphertext
//   plaintext  registered result
//   out_valid  plaintext valid
//   out_ready  consumer accepts plaintext
//   busy       high while rounds are running
//
// Optional feature macro: LWC_DECRYPT_ZEROIZE_EN
//   When defined, the state and key registers clear on the edge entering
//   DONE, and plaintext clears on the output handshake edge.
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// ROUND | one inverse round per cycle, counter NUM_ROUNDS-1 down to 0
// DONE  | plaintext held with out_valid until out_ready

module lwc_decrypt #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic [127:0] plaintext,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  localparam logic [3:0] LAST_R = 4'(NUM_ROUNDS - 1);

  fsm_t          fsm_q, fsm_d;
  logic [127:0]  state_q, key_q;
  logic [3:0]    rnd_q;
  logic [127:0]  rk, t_ark, t_mc, t_sr, round_out;

  // Forward ShiftRows source byte for output byte j.
  function automatic int sr_src(input int j);
    case (j)
      15: sr_src = 15;  14: sr_src = 10;  13: sr_src = 5;   12: sr_src = 0;
      11: sr_src = 11;  10: sr_src = 6;   9:  sr_src = 1;   8:  sr_src = 12;
      7:  sr_src = 7;   6:  sr_src = 2;   5:  sr_src = 13;  4:  sr_src = 8;
      3:  sr_src = 3;   2:  sr_src = 14;  1:  sr_src = 9;   default: sr_src = 4;
    endcase
  endfunction

  // Inverse round datapath for the round currently held in rnd_q.
  always_comb begin
    rk    = key_q ^ {4{28'd0, rnd_q}};
    t_ark = state_q ^ rk;
    t_mc  = t_ark;
    if (rnd_q != LAST_R) begin
      for (int k = 0; k < 4; k++)
        t_mc[32*k +: 32] = {t_ark[32*k +: 8], t_ark[32*k+8 +: 24]};
    end
    // Inverse of a gather is a scatter through the same table.
    t_sr = '0;
    for (int j = 0; j < 16; j++)
      t_sr[8*sr_src(j) +: 8] = t_mc[8*j +: 8];
    round_out = t_sr ^ {16{8'h63}};
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (in_valid) fsm_d = ROUND;
      ROUND:   if (rnd_q == 4'd0) fsm_d = DONE;
      DONE:    if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  assign in_ready = (fsm_q == IDLE);
  assign busy     = (fsm_q == ROUND);

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= IDLE;
      state_q   <= '0;
      key_q     <= '0;
      rnd_q     <= '0;
      plaintext <= '0;
      out_valid <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            state_q <= ciphertext;
            key_q   <= key;
            rnd_q   <= LAST_R;
          end
        end
        ROUND: begin
          state_q <= round_out;
          if (rnd_q != 4'd0) begin
            rnd_q <= rnd_q - 4'd1;
          end else begin
            // Final whitening with the original key completes decryption.
            plaintext <= round_out ^ key_q;
            out_valid <= 1'b1;
`ifdef LWC_DECRYPT_ZEROIZE_EN
            state_q <= '0;
            key_q   <= '0;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
`ifdef LWC_DECRYPT_ZEROIZE_EN
            plaintext <= '0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lwc_decrypt.sv
// tb_lwc_decrypt -- directed bench for lwc_decrypt (NUM_ROUNDS = 10).
// Ciphertexts are produced by a forward-cipher model; decrypted outputs are
// checked against the original plaintext or re-encrypted through that model.

module tb_lwc_decrypt;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] ciphertext = '0;
  logic [127:0] key = '0;
  logic [127:0] plaintext;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;

  int checks = 0;
  int errors = 0;

  // Forward ShiftRows: output bytes 15..0 take these input bytes.
  int SRC [15:0] = '{15, 10, 5, 0, 11, 6, 1, 12, 7, 2, 13, 8, 3, 14, 9, 4};

  lwc_decrypt #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ciphertext(ciphertext), .key(key), .plaintext(plaintext),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] enc(input logic [127:0] p, input logic [127:0] k);
    logic [127:0] s, o;
    s = p ^ k;
    for (int r = 0; r < 10; r++) begin
      s = s ^ {16{8'h63}};
      for (int j = 0; j < 16; j++) o[8*j +: 8] = s[8*SRC[j] +: 8];
      s = o;
      if (r < 9)
        for (int c = 0; c < 4; c++) s[32*c +: 32] = {o[32*c +: 24], o[32*c+24 +: 8]};
      s = s ^ k ^ {4{32'(r)}};
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts at the negedge just after the accept edge; lat counts posedges
  // until out_valid, bcnt counts samples with busy high.
  task automatic wait_out(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (!out_valid && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (busy) bcnt++;
  endtask

  task automatic start_block(input logic [127:0] c, input logic [127:0] k);
    in_valid = 1'b1; ciphertext = c; key = k;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  localparam logic [127:0] K1 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] P1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] K2 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  localparam logic [127:0] P2 = 128'hDEADBEEFCAFEF00D0123456789ABCDEF;

  initial begin
    int lat, bcnt, n, seen;
    logic [127:0] c1, c2;
    c1 = enc(P1, K1);
    c2 = enc(P2, K2);

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_plaintext", plaintext, 128'd0);
    chk("rst_state", dut.state_q, 128'd0);
    chk("rst_key", dut.key_q, 128'd0);
    chk("rst_rnd", 128'(dut.rnd_q), 128'd0);

    // Round trip
    start_block(c1, K1);
    ciphertext = ~c1; key = ~K1;   // must not disturb the running block
    wait_out(lat, bcnt);
    chk("rt_latency", 128'(lat), 128'd10);
    chk("rt_busy_cycles", 128'(bcnt), 128'd10);
    chk("rt_plaintext", plaintext, P1);
    chk("rt_in_ready_done", 128'(in_ready), 128'd0);
    handshake();
    chk("rt_hs_out_valid", 128'(out_valid), 128'd0);
    chk("rt_hs_in_ready", 128'(in_ready), 128'd1);
`ifdef LWC_DECRYPT_ZEROIZE_EN
    chk("zero_state", dut.state_q, 128'd0);
    chk("zero_key", dut.key_q, 128'd0);
    chk("zero_plaintext", plaintext, 128'd0);
`else
    chk("keep_state", dut.state_q, P1 ^ K1);
    chk("keep_key", dut.key_q, K1);
    chk("keep_plaintext", plaintext, P1);
`endif

    // Backpressure
    start_block(c2, K2);
    wait_out(lat, bcnt);
    chk("bp_latency", 128'(lat), 128'd10);
    in_valid = 1'b1; ciphertext = c1; key = K1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_plaintext", plaintext, P2);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_busy", 128'(busy), 128'd0);
    end
    in_valid = 1'b0;
    handshake();
    chk("bp_hs_out_valid", 128'(out_valid), 128'd0);
    chk("bp_hs_in_ready", 128'(in_ready), 128'd1);

    // Reset mid-operation at round counter 4
    start_block(c1, K1);
    n = 0;
    while (dut.rnd_q != 4'd4 && n < 20) begin @(negedge clk); n++; end
    chk("mid_reach_rnd4", 128'(n < 20), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_in_ready", 128'(in_ready), 128'd1);
    chk("mid_out_valid", 128'(out_valid), 128'd0);
    chk("mid_plaintext", plaintext, 128'd0);
    chk("mid_busy", 128'(busy), 128'd0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    chk("mid_no_late_out", 128'(seen), 128'd0);

    // Back-to-back with in_valid held high
    in_valid = 1'b1; ciphertext = c1; key = K1;
    @(negedge clk);
    ciphertext = c2; key = K2;
    wait_out(lat, bcnt);
    chk("b2b_a_latency", 128'(lat), 128'd10);
    chk("b2b_a_plaintext", plaintext, P1);
    handshake();
    chk("b2b_hs_in_ready", 128'(in_ready), 128'd1);
    chk("b2b_hs_busy", 128'(busy), 128'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_b_accepted", 128'(busy), 128'd1);
    wait_out(lat, bcnt);
    chk("b2b_b_latency", 128'(lat), 128'd10);
    chk("b2b_b_plaintext", plaintext, P2);
    handshake();

    // Edge values: re-encrypt the output and compare with the ciphertext
    start_block('0, '0);
    wait_out(lat, bcnt);
    chk("zero_busy_cycles", 128'(bcnt), 128'd10);
    chk("zero_roundtrip", enc(plaintext, '0), 128'd0);
    handshake();
    start_block({128{1'b1}}, {128{1'b1}});
    wait_out(lat, bcnt);
    chk("ones_busy_cycles", 128'(bcnt), 128'd10);
    chk("ones_roundtrip", enc(plaintext, {128{1'b1}}), {128{1'b1}});
    handshake();
    chk("end_in_ready", 128'(in_ready), 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
